// File: rtl/stopwatch_lap.sv
// MM:SS BCD stopwatch with synchronised raw buttons, split/hold, a circular lap memory with
// recall and a sticky overflow flag. Segment outputs are registered {g,f,e,d,c,b,a}, active-high.
module stopwatch_lap #(
    parameter int unsigned SPN  = 50_000_000,
    parameter int unsigned LAPS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      b_run,
    input  logic                      b_clr,
    input  logic                      b_rcl,
    output logic [6:0]                sec_0,
    output logic [6:0]                sec_1,
    output logic [6:0]                min_0,
    output logic [6:0]                min_1,
    output logic                      s_run,
    output logic                      s_hld,
    output logic                      s_rcl,
    output logic                      s_ovf,
    output logic [$clog2(LAPS+1)-1:0] lap_cnt,
    output logic [$clog2(LAPS)-1:0]   lap_idx
);
    localparam int unsigned CW = $clog2(LAPS + 1);
    localparam int unsigned IW = $clog2(LAPS);
    localparam int unsigned RW = IW + 1;
    localparam int unsigned PW = $clog2(SPN);
    localparam logic [PW-1:0] PreMax  = PW'(SPN - 1);
    localparam logic [CW-1:0] LapsCnt = CW'(LAPS);
    localparam logic [RW-1:0] LapsRd  = RW'(LAPS);
    localparam logic [IW-1:0] LastPtr = IW'(LAPS - 1);

    typedef enum logic [2:0] {StIdle, StRun, StHold, StStop, StRecall} state_e;

    function automatic logic [6:0] seg_dec(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    // Returns {wrap, m1, m0, s1, s0} after adding one second with full ripple carry.
    function automatic logic [16:0] bcd_inc(input logic [15:0] t);
        logic [3:0] s0, s1, m0, m1;
        logic       wrap;
        s0   = t[3:0];
        s1   = t[7:4];
        m0   = t[11:8];
        m1   = t[15:12];
        wrap = 1'b0;
        if (s0 != 4'd9) begin
            s0 = s0 + 4'd1;
        end else begin
            s0 = 4'd0;
            if (s1 != 4'd5) begin
                s1 = s1 + 4'd1;
            end else begin
                s1 = 4'd0;
                if (m0 != 4'd9) begin
                    m0 = m0 + 4'd1;
                end else begin
                    m0 = 4'd0;
                    if (m1 != 4'd5) begin
                        m1 = m1 + 4'd1;
                    end else begin
                        m1   = 4'd0;
                        wrap = 1'b1;
                    end
                end
            end
        end
        return {wrap, m1, m0, s1, s0};
    endfunction

    // Button path, bit order {rcl, clr, run}: two sync flops, a history flop, registered edge.
    logic [2:0] sync1_q, sync2_q, prev_q, ev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            ev_q    <= '0;
        end else begin
            sync1_q <= {b_rcl, b_clr, b_run};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            ev_q    <= sync2_q & ~prev_q;
        end
    end

    logic ev_run, ev_clr, ev_rcl;
    assign ev_run = ev_q[0];
    assign ev_clr = ev_q[1] & ~ev_q[0];
    assign ev_rcl = ev_q[2] & ~ev_q[1] & ~ev_q[0];

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [CW-1:0] cnt_q;
    logic [IW-1:0] wr_q;
    logic          push, clear;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        push    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            StIdle: begin
                if (ev_run) state_d = StRun;
                else if (ev_clr) clear = 1'b1;
            end
            StRun: begin
                if (ev_run) begin
                    state_d = StStop;
                end else if (ev_clr) begin
                    state_d = StHold;
                    push    = 1'b1;
                end
            end
            StHold: begin
                if (ev_run) state_d = StStop;
                else if (ev_clr) state_d = StRun;
            end
            StStop: begin
                if (ev_run) begin
                    state_d = StRun;
                end else if (ev_clr) begin
                    state_d = StIdle;
                    clear   = 1'b1;
                end else if (ev_rcl && cnt_q != '0) begin
                    state_d = StRecall;
                    idx_d   = '0;
                end
            end
            StRecall: begin
                if (ev_run) begin
                    state_d = StRun;
                    idx_d   = '0;
                end else if (ev_clr) begin
                    state_d = StStop;
                    idx_d   = '0;
                end else if (ev_rcl) begin
                    if (CW'(idx_q) + CW'(1) == cnt_q) begin
                        state_d = StStop;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    logic s_run_q, s_hld_q, s_rcl_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            s_run_q <= 1'b0;
            s_hld_q <= 1'b0;
            s_rcl_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            s_run_q <= (state_d == StRun) || (state_d == StHold);
            s_hld_q <= (state_d == StHold);
            s_rcl_q <= (state_d == StRecall);
        end
    end

    // Prescaler and BCD time; the prescaler only advances while the count is live.
    logic [PW-1:0] pre_q;
    logic [15:0]   time_q;
    logic          ovf_q;
    logic          running, tick;
    logic [16:0]   inc;

    assign running = (state_q == StRun) || (state_q == StHold);
    assign tick    = running && (pre_q == PreMax);
    assign inc     = bcd_inc(time_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q  <= '0;
            time_q <= '0;
            ovf_q  <= 1'b0;
        end else if (clear) begin
            pre_q  <= '0;
            time_q <= '0;
            ovf_q  <= 1'b0;
        end else if (running) begin
            if (tick) begin
                pre_q  <= '0;
                time_q <= inc[15:0];
                if (inc[16]) ovf_q <= 1'b1;
            end else begin
                pre_q <= pre_q + 1'b1;
            end
        end
    end

    // Lap memory: circular; once full the write pointer also marks the oldest entry.
    logic [15:0] lap_mem [LAPS];
    logic [15:0] frozen_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAPS; i++) lap_mem[i] <= '0;
            wr_q     <= '0;
            cnt_q    <= '0;
            frozen_q <= '0;
        end else if (clear) begin
            wr_q  <= '0;
            cnt_q <= '0;
        end else if (push) begin
            lap_mem[wr_q] <= time_q;
            frozen_q      <= time_q;
            wr_q          <= (wr_q == LastPtr) ? '0 : wr_q + 1'b1;
            if (cnt_q != LapsCnt) cnt_q <= cnt_q + 1'b1;
        end
    end

    logic [IW-1:0] oldest, rd_ptr;
    logic [RW-1:0] rd_sum;

    assign oldest = (cnt_q == LapsCnt) ? wr_q : '0;
    assign rd_sum = {1'b0, oldest} + {1'b0, idx_q};
    assign rd_ptr = (rd_sum >= LapsRd) ? IW'(rd_sum - LapsRd) : rd_sum[IW-1:0];

    logic [15:0] src;
    always_comb begin
        src = time_q;
        if (state_q == StHold) src = frozen_q;
        else if (state_q == StRecall) src = lap_mem[rd_ptr];
    end

    logic [6:0] sec_0_q, sec_1_q, min_0_q, min_1_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sec_0_q <= 7'h3F;
            sec_1_q <= 7'h3F;
            min_0_q <= 7'h3F;
            min_1_q <= 7'h3F;
        end else begin
            sec_0_q <= seg_dec(src[3:0]);
            sec_1_q <= seg_dec(src[7:4]);
            min_0_q <= seg_dec(src[11:8]);
            min_1_q <= seg_dec(src[15:12]);
        end
    end

    assign sec_0   = sec_0_q;
    assign sec_1   = sec_1_q;
    assign min_0   = min_0_q;
    assign min_1   = min_1_q;
    assign s_run   = s_run_q;
    assign s_hld   = s_hld_q;
    assign s_rcl   = s_rcl_q;
    assign s_ovf   = ovf_q;
    assign lap_cnt = cnt_q;
    assign lap_idx = idx_q;

endmodule

// File: tb/tb_stopwatch_lap.sv
// Bench for stopwatch_lap: a seconds-level model of the stopwatch checked every cycle,
// plus directed scenarios with hand-computed digit and status expectations.
module tb_stopwatch_lap;
    localparam int SPN  = 5;
    localparam int LAPS = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       b_run, b_clr, b_rcl;
    logic [6:0] sec_0, sec_1, min_0, min_1;
    logic       s_run, s_hld, s_rcl, s_ovf;
    logic [2:0] lap_cnt;
    logic [1:0] lap_idx;

    stopwatch_lap #(.SPN(SPN), .LAPS(LAPS)) dut (
        .clk     (clk),
        .rst     (rst),
        .b_run   (b_run),
        .b_clr   (b_clr),
        .b_rcl   (b_rcl),
        .sec_0   (sec_0),
        .sec_1   (sec_1),
        .min_0   (min_0),
        .min_1   (min_1),
        .s_run   (s_run),
        .s_hld   (s_hld),
        .s_rcl   (s_rcl),
        .s_ovf   (s_ovf),
        .lap_cnt (lap_cnt),
        .lap_idx (lap_idx)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit chk_en   = 1'b0;

    // Model: time held as whole seconds, laps as a queue of seconds, oldest first.
    localparam int MIdle = 0, MRun = 1, MHold = 2, MStop = 3, MRecall = 4;
    int       m_mode, m_secs, m_pre, m_frozen, m_idx, m_disp;
    bit       m_ovf;
    int       m_laps[$];
    bit [4:0] h_run, h_clr, h_rcl;
    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode = MIdle; m_secs = 0; m_pre = 0; m_frozen = 0; m_idx = 0; m_disp = 0;
        m_ovf = 1'b0;
        m_laps.delete();
        h_run = '0; h_clr = '0; h_rcl = '0;
    endtask

    task automatic model_edge();
        bit er, ec, ek, running;
        int src, old;
        h_run = {h_run[3:0], b_run};
        h_clr = {h_clr[3:0], b_clr};
        h_rcl = {h_rcl[3:0], b_rcl};
        // A press becomes an action three edges after it is first sampled.
        er = h_run[3] & ~h_run[4];
        ec = h_clr[3] & ~h_clr[4] & ~er;
        ek = h_rcl[3] & ~h_rcl[4] & ~er & ~ec;
        src = (m_mode == MHold) ? m_frozen : (m_mode == MRecall) ? m_laps[m_idx] : m_secs;
        running = (m_mode == MRun) || (m_mode == MHold);
        old = m_secs;
        case (m_mode)
            MIdle: begin
                if (er) m_mode = MRun;
                else if (ec) begin m_secs = 0; m_pre = 0; m_ovf = 0; m_laps.delete(); end
            end
            MRun: begin
                if (er) m_mode = MStop;
                else if (ec) begin
                    m_mode = MHold;
                    m_frozen = old;
                    if (m_laps.size() == LAPS) m_laps.delete(0);
                    m_laps.push_back(old);
                end
            end
            MHold: begin
                if (er) m_mode = MStop;
                else if (ec) m_mode = MRun;
            end
            MStop: begin
                if (er) m_mode = MRun;
                else if (ec) begin
                    m_mode = MIdle; m_secs = 0; m_pre = 0; m_ovf = 0; m_laps.delete();
                end else if (ek && m_laps.size() > 0) begin
                    m_mode = MRecall; m_idx = 0;
                end
            end
            default: begin
                if (er) begin m_mode = MRun; m_idx = 0; end
                else if (ec) begin m_mode = MStop; m_idx = 0; end
                else if (ek) begin
                    if (m_idx == m_laps.size() - 1) begin m_mode = MStop; m_idx = 0; end
                    else m_idx++;
                end
            end
        endcase
        if (running) begin
            if (m_pre == SPN - 1) begin
                m_pre = 0;
                if (m_secs == 3599) begin m_secs = 0; m_ovf = 1'b1; end
                else m_secs++;
            end else begin
                m_pre++;
            end
        end
        m_disp = src;
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else model_edge();
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic press(input bit r, input bit c, input bit k);
        b_run = r; b_clr = c; b_rcl = k;
        step();
        b_run = 1'b0; b_clr = 1'b0; b_rcl = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("sec_0", int'(sec_0), int'(seg_tab[m_disp % 10]));
            check("sec_1", int'(sec_1), int'(seg_tab[(m_disp % 60) / 10]));
            check("min_0", int'(min_0), int'(seg_tab[(m_disp / 60) % 10]));
            check("min_1", int'(min_1), int'(seg_tab[m_disp / 600]));
            check("s_run", int'(s_run), int'(m_mode == MRun || m_mode == MHold));
            check("s_hld", int'(s_hld), int'(m_mode == MHold));
            check("s_rcl", int'(s_rcl), int'(m_mode == MRecall));
            check("s_ovf", int'(s_ovf), int'(m_ovf));
            check("lap_cnt", int'(lap_cnt), m_laps.size());
            check("lap_idx", int'(lap_idx), m_idx);
        end
    end

    int r;

    initial begin
        rst = 1'b0; b_run = 1'b0; b_clr = 1'b0; b_rcl = 1'b0;
        model_reset();
        run(3);
        rst = 1'b1;
        chk_en = 1'b1;
        check("rst_digits", int'({min_1, min_0, sec_1, sec_0}), 28'h7E_FDFBF);
        check("rst_status", int'({s_run, s_hld, s_rcl, s_ovf, lap_cnt, lap_idx}), 0);

        // 1: run for 75 seconds
        press(1, 0, 0);
        r = cyc + 3;
        run_to(r + 377);
        check("t1_sec_0", int'(sec_0), 7'h6D);
        check("t1_sec_1", int'(sec_1), 7'h06);
        check("t1_min_0", int'(min_0), 7'h06);
        check("t1_min_1", int'(min_1), 7'h3F);
        check("t1_flags", int'({s_run, s_hld, s_ovf}), 3'b100);

        // 2: wrap past 59:59, then stop and clear
        run_to(r + 18002);
        check("t2_wrap_digits", int'({min_1, min_0, sec_1, sec_0}), 28'h7E_FDFBF);
        check("t2_ovf_set", int'(s_ovf), 1);
        press(1, 0, 0); run(4);
        press(0, 1, 0); run(4);
        check("t2_ovf_clear", int'(s_ovf), 0);
        check("t2_idle", int'({s_run, lap_cnt}), 0);

        // 3: split at 00:03, unfreeze at 00:07
        press(1, 0, 0);
        r = cyc + 3;
        run_to(r + 15);
        press(0, 1, 0);
        run_to(r + 20);
        check("t3_frozen", int'(sec_0), 7'h4F);
        check("t3_hold", int'({s_run, s_hld, lap_cnt}), 5'b11_001);
        run_to(r + 33);
        press(0, 1, 0);
        run_to(r + 38);
        check("t3_live", int'(sec_0), 7'h07);
        check("t3_unfreeze", int'({s_hld, lap_cnt}), 4'b0_001);
        press(1, 0, 0); run(4);
        press(0, 1, 0); run(4);

        // 4: five splits, four kept; recall walks oldest to newest
        press(1, 0, 0);
        r = cyc + 3;
        for (int t = 1; t <= 5; t++) begin
            run_to(r + 5 * t);
            press(0, 1, 0);
            run(1);
            press(0, 1, 0);
        end
        run_to(r + 32);
        press(1, 0, 0); run(4);
        check("t4_full", int'(lap_cnt), 4);
        press(0, 0, 1); run(4);
        check("t4_lap0", int'({sec_0, lap_idx, s_rcl}), {7'h5B, 2'd0, 1'b1});
        press(0, 0, 1); run(4);
        check("t4_lap1", int'({sec_0, lap_idx}), {7'h4F, 2'd1});
        press(0, 0, 1); run(4);
        check("t4_lap2", int'({sec_0, lap_idx}), {7'h66, 2'd2});
        press(0, 0, 1); run(4);
        check("t4_lap3", int'({sec_0, lap_idx}), {7'h6D, 2'd3});
        press(0, 0, 1); run(4);
        check("t4_exit", int'({s_rcl, s_run, lap_idx}), 0);

        // 5: run beats clr; recall with no laps is ignored
        press(1, 0, 0); run(4);
        press(1, 1, 0); run(4);
        check("t5_run_wins", int'({s_run, s_hld, lap_cnt}), 5'b00_100);
        press(0, 1, 0); run(4);
        press(1, 0, 0); run(4);
        press(1, 0, 0); run(4);
        press(0, 0, 1); run(4);
        check("t5_rcl_empty", int'({s_rcl, s_run, lap_cnt, lap_idx}), 0);

        // 6: async reset mid-count, then a long press gives a single run entry
        press(1, 0, 0); run(4);
        for (int i = 0; i < 10 && m_pre != 3; i++) step();
        check("t6_pre_at_3", m_pre, 3);
        rst = 1'b0;
        model_reset();
        #1;
        check("t6_rst_digits", int'({min_1, min_0, sec_1, sec_0}), 28'h7E_FDFBF);
        check("t6_rst_status", int'({s_run, s_hld, s_rcl, s_ovf, lap_cnt, lap_idx}), 0);
        run(2);
        rst = 1'b1;
        b_run = 1'b1;
        run(40);
        b_run = 1'b0;
        run(4);
        check("t6_single_entry", int'({s_run, s_hld}), 2'b10);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
